// File: rtl/cu_outputs_if.sv
// State-code and control-strobe bundle between the CU state register and the datapath.
// The master drives StateRegister; the slave (the decoder) drives the strobes.
interface cu_outputs_if;
    logic [3:0] StateRegister;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       PCSource1;
    logic       PCSource0;
    logic       ALUOp1;
    logic       ALUOp0;
    logic       ALUSrcB1;
    logic       ALUSrcB0;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       IllegalState;

    modport master (
        output StateRegister,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               PCSource1, PCSource0, ALUOp1, ALUOp0, ALUSrcB1, ALUSrcB0,
               ALUSrcA, RegWrite, RegDst, IllegalState
    );

    modport slave (
        input  StateRegister,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               PCSource1, PCSource0, ALUOp1, ALUOp0, ALUSrcB1, ALUSrcB0,
               ALUSrcA, RegWrite, RegDst, IllegalState
    );
endinterface

// File: rtl/cu_outputs.sv
// Decodes the multicycle CU state code into registered datapath control strobes.
// Latency: one clk from StateRegister to strobes.
// Backpressure: none; a new state code is accepted on every edge.
module cu_outputs (
    input  logic         clk,
    input  logic         reset,
    cu_outputs_if.slave  cu
);
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
        logic       aluSrcA;
        logic       regWrite;
        logic       regDst;
        logic       illegalState;
    } ctrl_t;

    ctrl_t decoded;
    ctrl_t ctrlReg;

    always_comb begin
        decoded = '0;
        case (cu.StateRegister)
            4'd0: begin
                decoded.pcWrite = 1'b1;
                decoded.memRead = 1'b1;
                decoded.irWrite = 1'b1;
                decoded.aluSrcB = 2'b01;
            end
            4'd1: decoded.aluSrcB = 2'b11;
            4'd2: begin
                decoded.aluSrcA = 1'b1;
                decoded.aluSrcB = 2'b10;
            end
            4'd3: begin
                decoded.iorD    = 1'b1;
                decoded.memRead = 1'b1;
            end
            4'd4: begin
                decoded.memtoReg = 1'b1;
                decoded.regWrite = 1'b1;
            end
            4'd5: begin
                decoded.iorD     = 1'b1;
                decoded.memWrite = 1'b1;
            end
            4'd6: begin
                decoded.aluSrcA = 1'b1;
                decoded.aluOp   = 2'b10;
            end
            4'd7: begin
                decoded.regWrite = 1'b1;
                decoded.regDst   = 1'b1;
            end
            4'd8: begin
                decoded.pcWriteCond = 1'b1;
                decoded.pcSource    = 2'b01;
                decoded.aluOp       = 2'b01;
                decoded.aluSrcA     = 1'b1;
            end
            4'd9: begin
                decoded.pcWrite  = 1'b1;
                decoded.pcSource = 2'b10;
            end
            // Codes 10-15 are unreachable in a healthy CU; park all strobes and flag it.
            default: decoded.illegalState = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) ctrlReg <= '0;
        else       ctrlReg <= decoded;
    end

    assign cu.PCWrite      = ctrlReg.pcWrite;
    assign cu.PCWriteCond  = ctrlReg.pcWriteCond;
    assign cu.IorD         = ctrlReg.iorD;
    assign cu.MemRead      = ctrlReg.memRead;
    assign cu.MemWrite     = ctrlReg.memWrite;
    assign cu.IRWrite      = ctrlReg.irWrite;
    assign cu.MemtoReg     = ctrlReg.memtoReg;
    assign cu.PCSource1    = ctrlReg.pcSource[1];
    assign cu.PCSource0    = ctrlReg.pcSource[0];
    assign cu.ALUOp1       = ctrlReg.aluOp[1];
    assign cu.ALUOp0       = ctrlReg.aluOp[0];
    assign cu.ALUSrcB1     = ctrlReg.aluSrcB[1];
    assign cu.ALUSrcB0     = ctrlReg.aluSrcB[0];
    assign cu.ALUSrcA      = ctrlReg.aluSrcA;
    assign cu.RegWrite     = ctrlReg.regWrite;
    assign cu.RegDst       = ctrlReg.regDst;
    assign cu.IllegalState = ctrlReg.illegalState;
endmodule

// File: tb/tb_cu_outputs.sv
// Randomized scoreboard bench for cu_outputs: expected strobes are queued at stimulus time
// and popped by a monitor one edge later.
module tb_cu_outputs;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [16:0] expQ[$];

    cu_outputs_if bus ();

    cu_outputs dut (
        .clk   (clk),
        .reset (reset),
        .cu    (bus.slave)
    );

    always #5 clk = ~clk;

    // Column-wise model: each strobe is expressed as the set of states that raise it.
    function automatic logic [16:0] model(input int s, input bit rst);
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
        if (rst) return '0;
        pcSource = (s == 8) ? 2'd1 : (s == 9) ? 2'd2 : 2'd0;
        aluOp    = (s == 6) ? 2'd2 : (s == 8) ? 2'd1 : 2'd0;
        aluSrcB  = (s == 0) ? 2'd1 : (s == 1) ? 2'd3 : (s == 2) ? 2'd2 : 2'd0;
        return {(s == 0 || s == 9), (s == 8), (s == 3 || s == 5), (s == 0 || s == 3),
                (s == 5), (s == 0), (s == 4), pcSource, aluOp, aluSrcB,
                (s == 2 || s == 6 || s == 8), (s == 4 || s == 7), (s == 7), (s > 9)};
    endfunction

    function automatic logic [16:0] actual();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.PCSource1, bus.PCSource0, bus.ALUOp1,
                bus.ALUOp0, bus.ALUSrcB1, bus.ALUSrcB0, bus.ALUSrcA, bus.RegWrite,
                bus.RegDst, bus.IllegalState};
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic step(input bit rst, input int s);
        @(negedge clk);
        reset = rst;
        bus.StateRegister = 4'(s);
        expQ.push_back(model(s, rst));
    endtask

    // Monitor: the strobes are presented on every edge once a transaction is queued.
    initial begin
        logic [16:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                got = actual();
                check("decode", got, expQ.pop_front());
                checks++;
                if ((bus.MemRead & bus.MemWrite) !== 1'b0 ||
                    (bus.PCWrite & bus.PCWriteCond) !== 1'b0) begin
                    errors++;
                    $display("FAIL invariant: got %b want no MemRead&MemWrite or PCWrite&PCWriteCond", got);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.StateRegister = 4'd0;
        step(1, 0);
        step(1, 0);
        for (int i = 0; i < 10; i++) step(0, i);
        step(0, 12);
        step(0, 3);
        step(0, 5);
        step(1, 5);
        step(0, 4);
        @(posedge clk);
        #2 bus.StateRegister = 4'd7;
        #1 check("toggle_hold7", actual(), model(4, 0));
        bus.StateRegister = 4'd4;
        #1 check("toggle_hold4", actual(), model(4, 0));
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 15) == 0), int'($urandom_range(0, 15)));
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
